clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Sequencing and arbitration controller for the integer clock divider (i_ref_clk / i_rst_n / i_clk_en / i_div_ratio / o_div_clk) in the multi-clock subsystem. Two requesters share the divider: A is the register file and B is the power manager. The block arbitrates ratio-change requests between them and applies each change glitch-free. It gates the divider, holds it in reset for a quiet window, loads the new ratio, then re-enables it and acknowledges the requester.

## Interface
- RATIO_W, 8, width of requested ratio (1..32)
- QUIET_CYCLES, 4, i_ref_clk cycles the divider is held gated/reset during a change (>=1)
- DEFAULT_RATIO, 1, value of o_div_ratio after reset

- i_ref_clk  in  1  reference clock; same clock as the divider
- i_rst_n  in  1  reset i_rst_n, asynchronous, active-low; clock i_ref_clk
- i_req_a  in  1  requester A change request, level, held until o_ack_a
- i_ratio_a  in  RATIO_W  requested ratio from A, stable while i_req_a high
- i_req_b  in  1  requester B change request, level, held until o_ack_b
- i_ratio_b  in  RATIO_W  requested ratio from B, stable while i_req_b high
- o_ack_a  out  1  one-cycle pulse: A's request completed
- o_ack_b  out  1  one-cycle pulse: B's request completed
- o_busy  out  1  change sequence in progress
- o_div_en  out  1  to divider i_clk_en
- o_div_rst_n  out  1  to divider i_rst_n (ANDed with i_rst_n at integration)
- o_div_ratio  out  32  to divider i_div_ratio, zero-extended

## Operation
- All outputs are driven from flops.
- Reset values:
  - state STEADY
  - o_div_ratio=DEFAULT_RATIO
  - o_div_en=0
  - o_div_rst_n=1
  - o_ack_a/b=0
  - o_busy=0
  - arbitration pointer favours A
- States:
  - STEADY: idle; o_div_en holds its last value; requests are sampled.
  - GATE: o_div_en=0, o_div_rst_n=0; a down-counter is loaded with QUIET_CYCLES-1 on entry.
  - LOAD: o_div_rst_n=1, o_div_en=0; o_div_ratio already holds the new value.
  - ACK: o_ack of the granted requester =1; o_div_en = (granted ratio != 0).
- STEADY transitions:
  - No request: stay in STEADY.
  - Granted request with ratio equal to o_div_ratio[RATIO_W-1:0] while o_div_en=1: go to ACK without gating; o_div_en stays 1.
  - Granted request otherwise: latch ratio and grant id, go to GATE.
- GATE: stays while the counter is nonzero and decrements each cycle. At counter 0, go to LOAD; o_div_ratio <= latched ratio on the same edge, unless the ratio is 0.
- LOAD -> ACK unconditionally.
- ACK -> STEADY unconditionally. Requests are ignored in ACK, so the requester drops its req in the ACK cycle or the one after it.
- Ratio 0 means disable. The full GATE sequence runs, o_div_ratio keeps its old value, and o_div_en ends at 0.
- Ratios 1 and 2..2^RATIO_W-1 pass through unchanged. Bypass behaviour for ratio 1 belongs to the divider.
- o_busy = state is GATE, LOAD or ACK.
- A request arriving while busy waits in STEADY and is served afterwards. Requests are never dropped.

## Timing
- Request sampled high at edge E0 in STEADY (gating path):
  - o_div_en/o_div_rst_n fall after E0.
  - GATE occupies QUIET_CYCLES cycles.
  - o_div_ratio updates and LOAD is entered at E0+QUIET_CYCLES.
  - ACK (o_ack high, o_div_en high) at E0+QUIET_CYCLES+1.
  - STEADY at E0+QUIET_CYCLES+2.
- Same-ratio path: o_ack is high for one cycle after E0; back in STEADY after E0+1.
- Back-to-back: minimum spacing between acks is QUIET_CYCLES+3 cycles for gating changes, 2 cycles for same-ratio.
- Simultaneous A and B requests in STEADY: exactly one is granted per the arbitration rule (Configuration); the other is granted in the next STEADY cycle.
- Asynchronous reset mid-sequence: all outputs return to reset values immediately. The in-flight request is not acknowledged, and requesters reissue.
- While in GATE, o_div_ratio never changes during a cycle in which o_div_rst_n=1 or o_div_en=1.

## Configuration
- CLK_DIV_CTRL_RR_EN defined:
  - Round-robin arbitration on simultaneous requests.
  - The requester not granted last wins; the pointer updates on every grant.
  - After reset, A wins the first tie.
- Undefined: fixed priority, B (power manager) always wins ties. No pointer flop exists.

## Test plan
- Reset, then A requests ratio 8 (QUIET_CYCLES=4):
  - o_div_en=0 and o_div_rst_n=0 for 4 cycles.
  - o_div_ratio=8 at E0+4.
  - o_ack_a and o_div_en=1 at E0+5.
  - Divider output period = 8 ref cycles.
- With ratio 8 active, B requests 8: o_ack_b one cycle later; o_div_en never drops; no GATE entry.
- A=6 and B=10 raised in the same cycle:
  - RR_EN defined: A served first, then B; final ratio 10.
  - Undefined: B first, then A; final ratio 6.
  - Each request gets exactly one ack.
- A requests 0 while running at 4: full gate sequence; o_ack_a; o_div_en stays 0; o_div_ratio stays 4.
- Assert i_rst_n low during GATE of a ratio-5 request: outputs go to reset values immediately, including o_div_ratio=DEFAULT_RATIO; no ack ever issued.
- B holds a request during A's sequence: B is not granted before A's ACK; o_ack_b arrives QUIET_CYCLES+2 cycles after A returns to STEADY.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Request/acknowledge and divider-control bundle shared by the divider sequencer and its requesters.
// The master side is a requester pair (register file A, power manager B); the slave side is clk_div_ctrl.
interface clk_div_ctrl_if #(
   parameter int RATIO_W = 8
);
   logic               i_req_a;
   logic [RATIO_W-1:0] i_ratio_a;
   logic               i_req_b;
   logic [RATIO_W-1:0] i_ratio_b;
   logic               o_ack_a;
   logic               o_ack_b;
   logic               o_busy;
   logic               o_div_en;
   logic               o_div_rst_n;
   logic [31:0]        o_div_ratio;

   modport master (
      output i_req_a, i_ratio_a, i_req_b, i_ratio_b,
      input  o_ack_a, o_ack_b, o_busy, o_div_en, o_div_rst_n, o_div_ratio
   );

   modport slave (
      input  i_req_a, i_ratio_a, i_req_b, i_ratio_b,
      output o_ack_a, o_ack_b, o_busy, o_div_en, o_div_rst_n, o_div_ratio
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free ratio-change sequencer and two-requester arbiter for the integer clock divider.
// Define CLK_DIV_CTRL_RR_EN for round-robin tie-breaking; otherwise requester B always wins ties.
module clk_div_ctrl #(
   parameter int RATIO_W       = 8,
   parameter int QUIET_CYCLES  = 4,
   parameter int DEFAULT_RATIO = 1
) (
   input  logic           i_ref_clk,
   input  logic           i_rst_n,
   clk_div_ctrl_if.slave  bus
);

   localparam int              CNT_W       = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(QUIET_CYCLES - 1);
   localparam logic [31:0]     RESET_RATIO = 32'(DEFAULT_RATIO);

   typedef enum logic [1:0] {
      STEADY = 2'd0,
      GATE   = 2'd1,
      LOAD   = 2'd2,
      ACK    = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   quiet_cnt;
   logic [RATIO_W-1:0] lat_ratio;
   logic               grant_b;
   logic [31:0]        div_ratio;
   logic               div_en;
   logic               div_rst_n;
   logic               ack_a;
   logic               ack_b;
   logic               busy;
`ifdef CLK_DIV_CTRL_RR_EN
   logic               favour_b;
`endif

   logic               any_req;
   logic               pick_b;
   logic [RATIO_W-1:0] pick_ratio;
   logic               same_ratio;

   // Arbitration between the two level requests
   always_comb begin
      pick_b = 1'b0;
      if (bus.i_req_a && bus.i_req_b) begin
`ifdef CLK_DIV_CTRL_RR_EN
         pick_b = favour_b;
`else
         pick_b = 1'b1;
`endif
      end else if (bus.i_req_b) begin
         pick_b = 1'b1;
      end else begin
         pick_b = 1'b0;
      end
      pick_ratio = pick_b ? bus.i_ratio_b : bus.i_ratio_a;
   end

   assign any_req    = bus.i_req_a || bus.i_req_b;
   // A running divider already at the requested ratio needs no gating
   assign same_ratio = div_en && (pick_ratio == div_ratio[RATIO_W-1:0]);

   // Change-sequence FSM with registered divider controls and acks
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= STEADY;
         quiet_cnt <= '0;
         lat_ratio <= '0;
         grant_b   <= 1'b0;
         div_ratio <= RESET_RATIO;
         div_en    <= 1'b0;
         div_rst_n <= 1'b1;
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         busy      <= 1'b0;
`ifdef CLK_DIV_CTRL_RR_EN
         favour_b  <= 1'b0;
`endif
      end else begin
         case (state)
            STEADY: begin
               if (any_req) begin
                  grant_b <= pick_b;
                  busy    <= 1'b1;
`ifdef CLK_DIV_CTRL_RR_EN
                  favour_b <= !pick_b;
`endif
                  if (same_ratio) begin
                     ack_a <= !pick_b;
                     ack_b <= pick_b;
                     state <= ACK;
                  end else begin
                     lat_ratio <= pick_ratio;
                     quiet_cnt <= CNT_LOAD;
                     div_en    <= 1'b0;
                     div_rst_n <= 1'b0;
                     ack_a     <= 1'b0;
                     ack_b     <= 1'b0;
                     state     <= GATE;
                  end
               end else begin
                  ack_a <= 1'b0;
                  ack_b <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            GATE: begin
               if (quiet_cnt != '0) begin
                  quiet_cnt <= quiet_cnt - CNT_W'(1);
               end else begin
                  // Ratio moves on the same edge reset releases; enable is still low
                  if (lat_ratio != '0) begin
                     div_ratio <= 32'(lat_ratio);
                  end
                  div_rst_n <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               ack_a  <= !grant_b;
               ack_b  <= grant_b;
               div_en <= (lat_ratio != '0);
               state  <= ACK;
            end
            ACK: begin
               ack_a <= 1'b0;
               ack_b <= 1'b0;
               busy  <= 1'b0;
               state <= STEADY;
            end
            default: begin
               div_en    <= 1'b0;
               div_rst_n <= 1'b1;
               ack_a     <= 1'b0;
               ack_b     <= 1'b0;
               busy      <= 1'b0;
               state     <= STEADY;
            end
         endcase
      end
   end

   assign bus.o_ack_a     = ack_a;
   assign bus.o_ack_b     = ack_b;
   assign bus.o_busy      = busy;
   assign bus.o_div_en    = div_en;
   assign bus.o_div_rst_n = div_rst_n;
   assign bus.o_div_ratio = div_ratio;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl with QUIET_CYCLES=4 and RATIO_W=8.
// Expected tie order follows CLK_DIV_CTRL_RR_EN when the bench is built with it.
module tb_clk_div_ctrl;

   logic ref_clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   clk_div_ctrl_if #(.RATIO_W(8)) bus ();

   clk_div_ctrl #(
      .RATIO_W       (8),
      .QUIET_CYCLES  (4),
      .DEFAULT_RATIO (1)
   ) dut (
      .i_ref_clk (ref_clk),
      .i_rst_n   (rst_n),
      .bus       (bus)
   );

   always #5 ref_clk = ~ref_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge ref_clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " ratio"}, bus.o_div_ratio, 32'd1);
      check({tag, " en"},    {31'd0, bus.o_div_en}, 32'd0);
      check({tag, " rst_n"}, {31'd0, bus.o_div_rst_n}, 32'd1);
      check({tag, " busy"},  {31'd0, bus.o_busy}, 32'd0);
      check({tag, " acks"},  {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd0);
   endtask

   // Caller has raised the granted request; the next posedge is E0.
   task automatic gate_seq(input string tag, input bit is_b, input logic [31:0] old_r,
                           input logic [31:0] new_r, input bit exp_en, input logic [7:0] late_b);
      for (int t = 1; t <= 4; t++) begin
         tick();
         if (t == 1 && late_b != 8'd0) begin
            bus.i_req_b   = 1'b1;
            bus.i_ratio_b = late_b;
         end
         check({tag, " gate en"},    {31'd0, bus.o_div_en}, 32'd0);
         check({tag, " gate rst_n"}, {31'd0, bus.o_div_rst_n}, 32'd0);
         check({tag, " gate ratio"}, bus.o_div_ratio, old_r);
         check({tag, " gate busy"},  {31'd0, bus.o_busy}, 32'd1);
         check({tag, " gate acks"},  {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd0);
      end
      tick();
      check({tag, " load rst_n"}, {31'd0, bus.o_div_rst_n}, 32'd1);
      check({tag, " load en"},    {31'd0, bus.o_div_en}, 32'd0);
      check({tag, " load ratio"}, bus.o_div_ratio, new_r);
      check({tag, " load acks"},  {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd0);
      tick();
      check({tag, " ack acks"},  {30'd0, bus.o_ack_a, bus.o_ack_b}, is_b ? 32'd1 : 32'd2);
      check({tag, " ack en"},    {31'd0, bus.o_div_en}, {31'd0, exp_en});
      check({tag, " ack busy"},  {31'd0, bus.o_busy}, 32'd1);
      check({tag, " ack ratio"}, bus.o_div_ratio, new_r);
      if (is_b) bus.i_req_b = 1'b0;
      else      bus.i_req_a = 1'b0;
      tick();
      check({tag, " done acks"}, {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd0);
      check({tag, " done busy"}, {31'd0, bus.o_busy}, 32'd0);
      check({tag, " done en"},   {31'd0, bus.o_div_en}, {31'd0, exp_en});
      check({tag, " done ratio"}, bus.o_div_ratio, new_r);
   endtask

   initial begin
      logic [31:0] tie_final;
      bus.i_req_a   = 1'b0;
      bus.i_ratio_a = 8'd0;
      bus.i_req_b   = 1'b0;
      bus.i_ratio_b = 8'd0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) tick();
      check_reset_vals("reset");
      rst_n = 1'b1;

      // A requests 8 from reset
      bus.i_req_a   = 1'b1;
      bus.i_ratio_a = 8'd8;
      gate_seq("a8", 1'b0, 32'd1, 32'd8, 1'b1, 8'd0);

      // B requests the running ratio: ack without gating
      bus.i_req_b   = 1'b1;
      bus.i_ratio_b = 8'd8;
      tick();
      check("same ack",   {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd1);
      check("same en",    {31'd0, bus.o_div_en}, 32'd1);
      check("same rst_n", {31'd0, bus.o_div_rst_n}, 32'd1);
      check("same busy",  {31'd0, bus.o_busy}, 32'd1);
      bus.i_req_b = 1'b0;
      tick();
      check("same done ack",  {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd0);
      check("same done en",   {31'd0, bus.o_div_en}, 32'd1);
      check("same done busy", {31'd0, bus.o_busy}, 32'd0);
      check("same ratio",     bus.o_div_ratio, 32'd8);

      // Simultaneous A=6 and B=10
      bus.i_req_a   = 1'b1;
      bus.i_ratio_a = 8'd6;
      bus.i_req_b   = 1'b1;
      bus.i_ratio_b = 8'd10;
`ifdef CLK_DIV_CTRL_RR_EN
      gate_seq("tie1 a", 1'b0, 32'd8, 32'd6, 1'b1, 8'd0);
      gate_seq("tie2 b", 1'b1, 32'd6, 32'd10, 1'b1, 8'd0);
      tie_final = 32'd10;
`else
      gate_seq("tie1 b", 1'b1, 32'd8, 32'd10, 1'b1, 8'd0);
      gate_seq("tie2 a", 1'b0, 32'd10, 32'd6, 1'b1, 8'd0);
      tie_final = 32'd6;
`endif
      for (int i = 0; i < 4; i++) begin
         tick();
         check("tie idle acks", {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd0);
      end
      check("tie final ratio", bus.o_div_ratio, tie_final);

      // Run at 4, then disable with ratio 0
      bus.i_req_a   = 1'b1;
      bus.i_ratio_a = 8'd4;
      gate_seq("a4", 1'b0, tie_final, 32'd4, 1'b1, 8'd0);
      bus.i_req_a   = 1'b1;
      bus.i_ratio_a = 8'd0;
      gate_seq("a0", 1'b0, 32'd4, 32'd4, 1'b0, 8'd0);

      // Same ratio while disabled must still gate
      bus.i_req_a   = 1'b1;
      bus.i_ratio_a = 8'd4;
      gate_seq("a4 re", 1'b0, 32'd4, 32'd4, 1'b1, 8'd0);

      // Reset in the middle of GATE for a ratio-5 request
      bus.i_req_b   = 1'b1;
      bus.i_ratio_b = 8'd5;
      tick();
      check("rst5 gate rst_n", {31'd0, bus.o_div_rst_n}, 32'd0);
      tick();
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      bus.i_req_b = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("post rst acks", {30'd0, bus.o_ack_a, bus.o_ack_b}, 32'd0);
         check("post rst ratio", bus.o_div_ratio, 32'd1);
      end

      // B raised during A's sequence is served right after
      bus.i_req_a   = 1'b1;
      bus.i_ratio_a = 8'd3;
      gate_seq("hold a", 1'b0, 32'd1, 32'd3, 1'b1, 8'd7);
      gate_seq("hold b", 1'b1, 32'd3, 32'd7, 1'b1, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
